spi_access_arbiter: RTL

Shares the single SPI master between two requesters: port 0 is the UART command path and port 1 is the register poll/readback engine. It arbitrates round-robin and latches the winning transaction's rw/address/data. It then sequences the SPI master through start, completion and result return, and steers the read data and done pulse back to the granted requester only. It sits between the UART data controller and the SPI master, in place of the direct start/rw/addr/data connection.

---
 rtl/spi_access_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/spi_access_arbiter.sv
// spi_access_arbiter: round-robin share of one SPI master between two requesters; WAIT timeout enabled by SPI_ARB_TIMEOUT_EN
module spi_access_arbiter #(
  parameter int SPI_ADDR_WIDTH = 6,
  parameter int SPI_DATA_WIDTH = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst,
  input  logic                      i_req0_valid,
  output logic                      o_req0_ready,
  input  logic                      i_req0_rw,
  input  logic [SPI_ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [SPI_DATA_WIDTH-1:0] i_req0_wdata,
  output logic                      o_req0_done,
  output logic [SPI_DATA_WIDTH-1:0] o_req0_rdata,
  output logic                      o_req0_err,
  input  logic                      i_req1_valid,
  output logic                      o_req1_ready,
  input  logic                      i_req1_rw,
  input  logic [SPI_ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [SPI_DATA_WIDTH-1:0] i_req1_wdata,
  output logic                      o_req1_done,
  output logic [SPI_DATA_WIDTH-1:0] o_req1_rdata,
  output logic                      o_req1_err,
  output logic                      o_spi_start,
  output logic                      o_spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0] o_spi_addr,
  output logic [SPI_DATA_WIDTH-1:0] o_spi_data,
  input  logic                      i_spi_data_valid,
  input  logic [SPI_DATA_WIDTH-1:0] i_spi_data,
  output logic                      o_busy,
  output logic                      o_last_grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_d;
  logic gnt, gnt_sel, hs, fin, timeout, err_q;
  logic [SPI_DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  if (TIMEOUT_CYCLES < 2) begin : g_chk
    $error("TIMEOUT_CYCLES must be >= 2");
  end
  assign gnt_sel = i_req0_valid && i_req1_valid ? !o_last_grant : i_req1_valid;
  assign o_req0_ready = state == IDLE && i_req0_valid && !gnt_sel;
  assign o_req1_ready = state == IDLE && i_req1_valid && gnt_sel;
  assign hs = o_req0_ready || o_req1_ready;
  assign fin = state == WAIT && (i_spi_data_valid || timeout);
  assign o_spi_start = state == ISSUE;
  assign o_busy = state != IDLE;
  assign o_req0_done = state == DONE && !gnt;
  assign o_req1_done = state == DONE && gnt;
  assign o_req0_rdata = rdata0_q;
  assign o_req1_rdata = rdata1_q;
  assign o_req0_err = o_req0_done && err_q;
  assign o_req1_err = o_req1_done && err_q;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign timeout = state == WAIT && !i_spi_data_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (fin) err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q = 1'b0;
`endif
  always_comb begin
    state_d = state == IDLE  ? (hs ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (fin ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      o_last_grant <= 1'b1;
      o_spi_rw <= 1'b0;
      o_spi_addr <= '0;
      o_spi_data <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_d;
      if (hs) begin
        gnt <= gnt_sel;
        o_spi_rw <= gnt_sel ? i_req1_rw : i_req0_rw;
        o_spi_addr <= gnt_sel ? i_req1_addr : i_req0_addr;
        o_spi_data <= gnt_sel ? i_req1_wdata : i_req0_wdata;
      end
      if (fin && gnt) rdata1_q <= i_spi_data | {SPI_DATA_WIDTH{timeout}};
      if (fin && !gnt) rdata0_q <= i_spi_data | {SPI_DATA_WIDTH{timeout}};
      if (state == DONE) o_last_grant <= gnt;
    end
  end
endmodule
